// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed N-digit 7-segment display driver. A packed nibble vector,
//   per-digit decimal points and per-digit blank requests are latched into
//   shadow registers on a load strobe. The display time-multiplexes one digit
//   per slot onto a shared active-low segment bus, with active-low digit
//   enables. Each slot begins with an anti-ghost window where every output is
//   dark. Supports hex/BCD decode and leading-zero suppression.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   value       packed nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in       decimal point request per digit, 1 = lit
//   blank_in    force digit dark, 1 = blank (overrides dp)
//   load        1-cycle strobe capturing value/dp_in/blank_in
//   an          digit enables, active-low, at most one low
//   seg         segments g..a = seg[6:0], active-low
//   dp          decimal point, active-low
//   frame_tick  1-cycle pulse on the first cycle of slot 0 after a wrap
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GHOST_CYC   = 16,
  parameter int HEX_MODE    = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;

  logic                    slot_end;
  logic                    frame_end;
  logic                    ghost;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_lz;
  logic [6:0]              seg_next;
  logic                    dp_next;

  // Active-low segment patterns, g..a
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign ghost     = (cnt < CW'(GHOST_CYC));

  always_comb begin
    lz_mask   = '0;
    an_sel    = '1;
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    // A digit is a leading zero when it and every nibble above it are zero;
    // digit 0 always shows.
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lz_mask[k] = (LZ_SUPPRESS != 0) && ((sh_val >> (4 * k)) == '0);
    end
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (idx == IW'(j)) begin
        nib       = sh_val[4*j +: 4];
        cur_dp    = sh_dp[j];
        cur_blank = sh_blank[j];
        cur_lz    = lz_mask[j];
        an_sel[j] = 1'b0;
      end
    end
    seg_next = decode(nib);
    dp_next  = ~cur_dp;
    if (cur_blank) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end else if (cur_lz || (HEX_MODE == 0 && nib > 4'd9)) begin
      // Suppressed or non-decimal digits go dark but keep their dp
      seg_next = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end

      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_tick <= frame_end;

      // Outputs reflect the pre-edge cnt/idx/shadow, so they trail by a cycle
      if (ghost) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= an_sel;
        seg <= seg_next;
        dp  <= dp_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Drives two display drivers with identical stimulus (hex + leading-zero
//   suppression on one, plain BCD without suppression on the other). The
//   reference model derives every output from the number of edges since reset
//   and the latched shadow contents; a monitor pops expected vectors and
//   compares them on the falling edge.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 20;
  localparam int GC = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [3:0]  a_an, b_an;
  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_ft, b_ft;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .GHOST_CYC(GC), .HEX_MODE(1), .LZ_SUPPRESS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .an(a_an), .seg(a_seg), .dp(a_dp), .frame_tick(a_ft)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .GHOST_CYC(GC), .HEX_MODE(0), .LZ_SUPPRESS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .an(b_an), .seg(b_seg), .dp(b_dp), .frame_tick(b_ft)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {an[3:0], seg[6:0], dp, frame_tick}
  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [6:0] font [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: edges since reset, plus the latched shadow contents
  int          k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;

  // Output produced by the edge that leaves kk edges behind it
  function automatic logic [12:0] expect_out(int kk, logic [15:0] v, logic [3:0] d,
                                             logic [3:0] b, bit hex, bit lz);
    int         c = kk % RD;
    int         i = (kk / RD) % N;
    logic       ft = ((kk % FRAME) == FRAME - 1);
    logic [3:0] an;
    logic [3:0] nib;
    logic [6:0] s;
    logic       p;
    if (c < GC) return {4'hF, 7'h7F, 1'b1, ft};
    an    = 4'hF;
    an[i] = 1'b0;
    nib   = v[4*i +: 4];
    if (b[i]) begin
      s = 7'h7F;
      p = 1'b1;
    end else begin
      p = ~d[i];
      if (lz && i > 0 && (v >> (4 * i)) == 16'h0) s = 7'h7F;
      else if (!hex && nib > 4'd9) s = 7'h7F;
      else s = font[nib];
    end
    return {an, s, p, ft};
  endfunction

  task automatic edge_model();
    exp_t e;
    if (rst) begin
      e.a = {4'hF, 7'h7F, 1'b1, 1'b0};
      e.b = {4'hF, 7'h7F, 1'b1, 1'b0};
      k = 0;
      m_val = '0;
      m_dp = '0;
      m_blank = '0;
    end else begin
      e.a = expect_out(k, m_val, m_dp, m_blank, 1'b1, 1'b1);
      e.b = expect_out(k, m_val, m_dp, m_blank, 1'b0, 1'b0);
      k++;
      if (load) begin
        m_val = value;
        m_dp = dp_in;
        m_blank = blank_in;
      end
    end
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    edge_model();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] b);
    value = v;
    dp_in = d;
    blank_in = b;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic check(string name, logic [12:0] got, logic [12:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
               name, $time, got[12:9], got[8:2], got[1], got[0],
               want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  task automatic check_onehot(string name, logic [3:0] an);
    n_checks++;
    if ($countones(~an) > 1) begin
      n_fail++;
      $display("FAIL %s t=%0t: an=%b, want at most one low", name, $time, an);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("dut_a_outputs", {a_an, a_seg, a_dp, a_ft}, e.a);
      check("dut_b_outputs", {b_an, b_seg, b_dp, b_ft}, e.b);
      check_onehot("dut_a_onehot", a_an);
      check_onehot("dut_b_onehot", b_an);
    end
  end

  initial begin
    logic [15:0] v;
    int          keep;

    rst = 1'b1;
    run(3);
    rst = 1'b0;

    do_load(16'h1234, 4'b0000, 4'b0000);
    run(2 * FRAME);
    do_load(16'h00AF, 4'b0000, 4'b0000);
    run(FRAME);
    do_load(16'h0050, 4'b0100, 4'b0000);
    run(FRAME);
    do_load(16'h0050, 4'b0001, 4'b0001);
    run(FRAME);

    // Inputs change without load: display must hold
    value = 16'h9999;
    dp_in = 4'hF;
    blank_in = 4'h0;
    run(FRAME);

    // Reset in the middle of slot 2's active window (k advances every cycle)
    while ((k % FRAME) != 2 * RD + GC + 3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME);

    // A load coinciding with reset is ignored
    do_load(16'h0304, 4'b0010, 4'b0000);
    run(RD);
    rst = 1'b1;
    value = 16'hFFFF;
    load = 1'b1;
    cycle();
    load = 1'b0;
    rst = 1'b0;
    run(FRAME);

    // Randomized loads at arbitrary points in the scan, occasional resets
    repeat (40) begin
      run($urandom_range(1, 70));
      keep = $urandom_range(0, 4);
      v = 16'($urandom);
      if (keep < 4) v = v & ~(16'hFFFF << (4 * keep));
      do_load(v, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      if ($urandom_range(0, 9) == 0) begin
        run($urandom_range(1, 40));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    run(FRAME + 5);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d pending, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
